// File: rtl/fifo_ms_drain.sv
// Read-side controller for the multi-stream tagged FIFO.
// Picks a non-empty, enabled flux by round-robin, issues a one-hot read
// strobe, captures the returned tagged word into a 2-entry output buffer
// and presents it on a single valid/ready stream as data + tag.
//
// Handshake: a word transfers on m_data/m_tag in any cycle where
// m_valid & m_ready are both high at the rising edge; m_valid never drops
// and the head word never changes while m_valid & !m_ready.
module fifo_ms_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int FLUX         = 2,
    parameter int READ_LATENCY = 1,
    localparam int TAG_WIDTH   = $clog2(FLUX),
    localparam int WIDTH       = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLUX-1:0]       fifo_empty,
    output logic [FLUX-1:0]       fifo_read,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic [FLUX-1:0]       flux_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  tag_err
);

    // Architectural state
    logic [1:0]           occ_q, occ_d;          // buffered words (0..2)
    logic                 infl_q, infl_d;        // read issued last cycle, data due now
    logic [TAG_WIDTH-1:0] last_q, last_d;        // last granted flux
    logic [TAG_WIDTH-1:0] pend_tag_q, pend_tag_d; // tag of the in-flight read
    logic                 tag_err_q, tag_err_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 rst_dly_q, rst_dly_d;  // high in the cycle after a reset cycle
    logic [WIDTH-1:0]     mem_q [2];
    logic [WIDTH-1:0]     mem_d [2];

    // Combinational helpers
    logic [FLUX-1:0]      eligible;
    logic                 found;
    logic [TAG_WIDTH-1:0] winner;
    logic                 pop;
    logic                 issue;
    logic [2:0]           level;
    logic                 push;
    logic [TAG_WIDTH-1:0] push_tag;

    // Round-robin search starting just after the last grant
    always_comb begin
        eligible = ~fifo_empty & flux_en;
        found    = 1'b0;
        winner   = '0;
        for (int k = 1; k <= FLUX; k++) begin
            logic [TAG_WIDTH-1:0] idx;
            idx = TAG_WIDTH'((int'(last_q) + k) % FLUX);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Issue decision: reserve buffer space for everything already in flight,
    // crediting a word that leaves this cycle so full throughput is kept
    always_comb begin
        pop       = m_valid & m_ready;
        level     = 3'(occ_q) + 3'(infl_q) - 3'(pop);
        issue     = found && (level < 3'd2) && !rst && !rst_dly_q;
        fifo_read = issue ? (FLUX'(1) << winner) : '0;
    end

    // Next-state: capture path, buffer bookkeeping, sticky tag check
    always_comb begin
        if (READ_LATENCY == 0) begin
            push     = issue;
            push_tag = winner;
        end else begin
            push     = infl_q;
            push_tag = pend_tag_q;
        end

        infl_d     = (READ_LATENCY != 0) && issue;
        pend_tag_d = issue ? winner : pend_tag_q;
        last_d     = issue ? winner : last_q;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        rst_dly_d  = rst;

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (push) begin
            mem_d[wr_ptr_q] = {push_tag, fifo_dout[DATA_WIDTH-1:0]};
        end

        tag_err_d = tag_err_q;
        if (push && (fifo_dout[WIDTH-1 -: TAG_WIDTH] != push_tag)) begin
            tag_err_d = 1'b1;
        end
    end

    // State registers; reset discards anything buffered or in flight
    always_ff @(posedge clk) begin
        rst_dly_q <= rst_dly_d;
        if (rst) begin
            occ_q      <= '0;
            infl_q     <= 1'b0;
            last_q     <= TAG_WIDTH'(FLUX - 1);
            pend_tag_q <= '0;
            tag_err_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            last_q     <= last_d;
            pend_tag_q <= pend_tag_d;
            tag_err_q  <= tag_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
        end
    end

    // Output stream comes straight from the buffer head
    always_comb begin
        m_valid = (occ_q != 2'd0);
        m_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
        m_tag   = mem_q[rd_ptr_q][WIDTH-1 -: TAG_WIDTH];
        tag_err = tag_err_q;
    end

endmodule

// File: doc/fifo_ms_drain.md
Name: fifo_ms_drain

Overview:
Read-side controller for the multi-stream tagged FIFO. It watches the per-flux empty flags and selects a non-empty, enabled flux by round-robin. It issues a one-hot read strobe and captures the returned tagged word. The word goes out on a single valid/ready stream as separate data and tag. It sits between the multi-stream FIFO read port and a downstream consumer that processes all fluxes on one channel.

Parameters:
DATA_WIDTH, 8, payload width in bits
FLUX, 2, number of independent streams (>=2)
READ_LATENCY, 1, cycles from fifo_read assertion to valid fifo_dout; legal values 0 or 1
TAG_WIDTH, $clog2(FLUX), derived, not overridden
WIDTH, DATA_WIDTH+TAG_WIDTH, derived tagged-word width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
fifo_empty  in  FLUX  per-flux empty flag from the FIFO, current every cycle
fifo_read  out  FLUX  one-hot read strobe, or all-zero
fifo_dout  in  WIDTH  tagged read word: tag in [WIDTH-1 -: TAG_WIDTH], data in [DATA_WIDTH-1:0]
flux_en  in  FLUX  per-flux service enable
m_valid  out  1  output word valid
m_ready  in  1  consumer accepts the word when m_valid & m_ready
m_data  out  DATA_WIDTH  payload
m_tag  out  TAG_WIDTH  flux index of the payload
tag_err  out  1  sticky tag-mismatch flag

Behaviour:
- Reset values:
  - fifo_read=0, m_valid=0, m_data=0, m_tag=0, tag_err=0.
  - Output buffer occupancy occ=0, in-flight count infl=0.
  - Round-robin pointer last=FLUX-1, so flux 0 has first priority.
- Eligibility: eligible[i] = !fifo_empty[i] & flux_en[i].
- Arbitration:
  - Search starts at last+1 and wraps modulo FLUX; the first eligible index wins.
  - On an issued read, last <= winner.
  - Non-issuing cycles leave last unchanged.
- Buffering: 2-entry output FIFO. Entries are {expected tag, data}.
- Issue rule: fifo_read[winner]=1 iff any eligible and (occ + infl - pop) < 2, where pop = m_valid & m_ready.
  - This is a combinational path from m_ready to fifo_read, allowed by design.
  - It sustains 1 word/cycle with m_ready held high.
- Never more than one bit of fifo_read is set. Never read a flux whose fifo_empty is 1 in the same cycle.
- READ_LATENCY=1:
  - Issued tag is registered; infl=1 for the next cycle.
  - fifo_dout is captured at the end of that cycle.
- READ_LATENCY=0:
  - fifo_dout is captured at the end of the issuing cycle; infl is always 0.
- Capture:
  - The entry is written with the issued (expected) tag and fifo_dout data.
  - If the fifo_dout tag field differs from the expected tag, tag_err <= 1.
  - tag_err stays 1 until rst. The word is still forwarded.
- Output:
  - m_valid = occ>0; m_data/m_tag come from the head entry.
  - Head is held stable while m_valid & !m_ready.
- Ordering: output order equals read-issue order, with no loss or duplication.
- Simultaneous push and pop: occ is unchanged and the head advances. Buffer pointers are 1 bit and wrap.
- flux_en and fifo_empty changes take effect in the same cycle's arbitration. Already-issued reads complete normally.
- Reset mid-operation: occ, infl, last and tag_err return to reset values. In-flight and buffered words are discarded. fifo_read=0 during and in the cycle after any rst cycle.

Test Plan:
1. Idle: rst then all fifo_empty=1 for 10 cycles -> fifo_read=0, m_valid=0 throughout.
2. Round-robin, FLUX=2, READ_LATENCY=1:
   - Stimulus: 3 words per flux (0xA0..A2 on tag 0, 0xB0..B2 on tag 1), m_ready=1.
   - Expected: fifo_read sequence 01,10,01,10,01,10 on consecutive cycles.
   - Expected: m_data A0,B0,A1,B1,A2,B2 with m_tag 0,1,0,1,0,1, first m_valid 2 cycles after first read, then back-to-back.
3. Backpressure: m_ready=0 with 5 words queued -> exactly 2 reads issued, then fifo_read=0 and m_data held stable. Release m_ready -> remaining 3 read, all 5 delivered in order.
4. Masking: flux_en=2'b10, both fluxes non-empty -> only fifo_read=10 asserted. Set flux_en=2'b11 -> flux 0 served on the next grant.
5. Tag error: on a read of flux 1, drive fifo_dout tag field 0 -> tag_err=1 on the following cycle and stays 1. m_tag=1 for that word.
6. Reset mid-stream: rst asserted with occ=2 and infl=1 -> next cycle m_valid=0, tag_err=0, fifo_read=0. After release, flux 0 is granted first.
